// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Power-up and recovery sequencer for the rPLL feeding the video pixel clocks.
// Pulses the PLL reset, waits for lock with a timeout and bounded retries,
// qualifies lock over a stable window, then releases the downstream
// active-low reset. Loss of lock in RUN tears the pipeline down and restarts.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRY        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_rst_n,
    output logic       locked,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    // One counter serves every timed state, so it is sized for the longest window.
    localparam int CNT_MAX_A = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYC) ? CNT_MAX_A : LOCK_STABLE_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             sync1_reg;
    logic             lock_s;
    logic [3:0]       retry_next;
    logic             lost_next;
    logic             attempt_fail;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            sync1_reg <= pll_lock;
            lock_s    <= sync1_reg;
        end
    end

    // Next-state, retry bookkeeping and loss-of-lock detection.
    always_comb begin
        state_next   = state_reg;
        retry_next   = retry_cnt;
        lost_next    = 1'b0;
        attempt_fail = 1'b0;
        case (state_reg)
            RESET_PLL: if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s)                         state_next   = STABLE;
                else if (cnt_reg == TIMEOUT_LAST)   attempt_fail = 1'b1;
            end
            // A drop on the final counting cycle still counts as a failure.
            STABLE: begin
                if (!lock_s)                        attempt_fail = 1'b1;
                else if (cnt_reg == STABLE_LAST)    state_next   = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = RESET_PLL;
                    lost_next  = 1'b1;
                    retry_next = 4'd0;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = RESET_PLL;
        endcase
        if (attempt_fail) begin
            if (retry_cnt >= RETRY_LIMIT) begin
                state_next = FAIL;
            end else begin
                state_next = RESET_PLL;
                retry_next = retry_cnt + 4'd1;
            end
        end
    end

    // State, shared counter and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_PLL;
            cnt_reg   <= '0;
            retry_cnt <= 4'd0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                cnt_reg <= '0;
            else if (state_reg != RUN && state_reg != FAIL)
                cnt_reg <= cnt_reg + CNT_W'(1);
            retry_cnt <= retry_next;
            pll_reset <= (state_next == RESET_PLL) || (state_next == FAIL);
            sys_rst_n <= (state_next == RUN);
            locked    <= (state_next == RUN);
            fail      <= (state_next == FAIL);
            lock_lost <= lost_next;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Scenario bench: each task drives the PLL lock / reset stimulus, queues the
// output vector expected at specific clock edges, and compares it as the DUT
// reaches those edges. Output vector: {pll_reset, sys_rst_n, locked, fail,
// lock_lost, retry_cnt[3:0]}.
module tb_pll_lock_supervisor;

    localparam int RP = 4;
    localparam int TO = 50;
    localparam int ST = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_rst_n, locked, fail, lock_lost;
    logic [3:0] retry_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [8:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .RST_PULSE_CYC   (RP),
        .LOCK_TIMEOUT_CYC(TO),
        .LOCK_STABLE_CYC (ST),
        .MAX_RETRY       (MR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .pll_reset(pll_reset),
        .sys_rst_n(sys_rst_n),
        .locked   (locked),
        .fail     (fail),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    always #10 clk = ~clk;

    // Edge counter: after posedge N the negedge sample sees cyc == N.
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] obs();
        return {pll_reset, sys_rst_n, locked, fail, lock_lost, retry_cnt};
    endfunction
    function automatic logic [8:0] v_rst(input logic [3:0] r);
        return {5'b10000, r};
    endfunction
    function automatic logic [8:0] v_wait(input logic [3:0] r);
        return {5'b00000, r};
    endfunction
    function automatic logic [8:0] v_run(input logic [3:0] r);
        return {5'b01100, r};
    endfunction
    function automatic logic [8:0] v_fail(input logic [3:0] r);
        return {5'b10010, r};
    endfunction
    function automatic logic [8:0] v_lost();
        return {5'b10001, 4'd0};
    endfunction

    task automatic push(input int c, input logic [8:0] v, input string name);
        exp_t e;
        e.cyc = c; e.v = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic do_reset(output int base);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
    endtask

    task automatic test_reset();
        #5 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== v_rst(4'd0)) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs(), v_rst(4'd0));
        end else $display("ok reset_async %b", obs());
        @(negedge clk);
        checks++;
        if (obs() !== v_rst(4'd0)) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs(), v_rst(4'd0));
        end else $display("ok reset_hold %b", obs());
    endtask

    task automatic test_clean_start();
        int base; exp_t e;
        pll_lock = 1'b0;
        do_reset(base);
        for (int i = 1; i < RP; i++) push(base + i, v_rst(4'd0), "clean_pll_reset_high");
        push(base + RP, v_wait(4'd0), "clean_pll_reset_fall");
        push(base + 14 + 10, v_wait(4'd0), "clean_before_run");
        push(base + 14 + 11, v_run(4'd0), "clean_run");
        push(base + 14 + 15, v_run(4'd0), "clean_run_hold");
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (cyc == base + 14) pll_lock = 1'b1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - base, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - base, obs());
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++; errors++;
            $display("FAIL %s: never reached, got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    task automatic test_chatter();
        int base; exp_t e;
        pll_lock = 1'b0;
        do_reset(base);
        // STABLE entered at base+7; the 1-cycle drop lands on its final count.
        push(base + 14, v_wait(4'd0), "chatter_in_stable");
        push(base + 15, v_rst(4'd1), "chatter_retry_pulse");
        push(base + 18, v_rst(4'd1), "chatter_pulse_end");
        push(base + 19, v_wait(4'd1), "chatter_pulse_fall");
        push(base + 27, v_wait(4'd1), "chatter_before_run");
        push(base + 28, v_run(4'd1), "chatter_run");
        push(base + 32, v_run(4'd1), "chatter_run_hold");
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (cyc == base + 4)  pll_lock = 1'b1;
            if (cyc == base + 12) pll_lock = 1'b0;
            if (cyc == base + 13) pll_lock = 1'b1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - base, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - base, obs());
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++; errors++;
            $display("FAIL %s: never reached, got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    // Continues from RUN with retry_cnt=1 left by the chatter scenario.
    task automatic test_loss_in_run();
        int t; exp_t e;
        t = cyc;
        pll_lock = 1'b0;
        push(t + 2, v_run(4'd1), "loss_still_run");
        push(t + 3, v_lost(), "loss_teardown");
        push(t + 4, v_rst(4'd0), "loss_pulse_once");
        push(t + 6, v_rst(4'd0), "loss_pulse_end");
        push(t + 7, v_wait(4'd0), "loss_pulse_fall");
        push(t + 20, v_wait(4'd0), "loss_before_rerun");
        push(t + 21, v_run(4'd0), "loss_rerun");
        push(t + 25, v_run(4'd0), "loss_rerun_hold");
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (cyc == t + 10) pll_lock = 1'b1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - t, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - t, obs());
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++; errors++;
            $display("FAIL %s: never reached, got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    task automatic test_timeout_retry();
        int base; int w; exp_t e;
        pll_lock = 1'b0;
        do_reset(base);
        push(base + RP - 1, v_rst(4'd0), "to_first_pulse");
        for (int a = 0; a <= MR; a++) begin
            w = base + RP + a * (TO + RP);
            push(w, v_wait(4'(a)), "to_wait_enter");
            push(w + TO - 1, v_wait(4'(a)), "to_wait_last");
            if (a < MR) begin
                push(w + TO, v_rst(4'(a + 1)), "to_retry_pulse");
                push(w + TO + RP - 1, v_rst(4'(a + 1)), "to_retry_pulse_end");
            end else begin
                push(w + TO, v_fail(4'(MR)), "to_fail");
                push(w + TO + 40, v_fail(4'(MR)), "to_fail_held");
            end
        end
        for (int k = 0; k < 210; k++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - base, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - base, obs());
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++; errors++;
            $display("FAIL %s: never reached, got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    // Entered while in FAIL; lock is held high throughout.
    task automatic test_mid_reset();
        int base; exp_t e;
        pll_lock = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== v_rst(4'd0)) begin
            errors++;
            $display("FAIL fail_async_reset: got %b expected %b", obs(), v_rst(4'd0));
        end else $display("ok fail_async_reset %b", obs());
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        push(base + 3, v_rst(4'd0), "mid_pulse_end");
        push(base + 4, v_wait(4'd0), "mid_pulse_fall");
        push(base + 8, v_wait(4'd0), "mid_in_stable");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - base, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - base, obs());
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== v_rst(4'd0)) begin
            errors++;
            $display("FAIL stable_async_reset: got %b expected %b", obs(), v_rst(4'd0));
        end else $display("ok stable_async_reset %b", obs());
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        // Lock already high: STABLE follows WAIT_LOCK entry on the next edge.
        push(base + 3, v_rst(4'd0), "restart_pulse_end");
        push(base + 4, v_wait(4'd0), "restart_pulse_fall");
        push(base + 12, v_wait(4'd0), "restart_before_run");
        push(base + 13, v_run(4'd0), "restart_run");
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || obs() !== e.v) begin
                    errors++;
                    $display("FAIL %s cyc=%0d: got %b expected %b", e.name, e.cyc - base, obs(), e.v);
                end else $display("ok %s cyc=%0d %b", e.name, e.cyc - base, obs());
            end
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); checks++; errors++;
            $display("FAIL %s: never reached, got %b expected %b", e.name, obs(), e.v);
        end
    endtask

    initial begin
        test_reset();
        test_clean_start();
        test_chatter();
        test_loss_in_run();
        test_timeout_retry();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
